// File: rtl/varredura_vga.sv
// Raster scan generator and VGA output stage: walks the 640x480@60 Hz raster,
// reads the 40x30 cell map one clk ahead and drives registered DAC/sync outputs.
module varredura_vga #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mapa_R,
    input  logic [1:0] mapa_G,
    input  logic [1:0] mapa_B,
    output logic       vga_read,
    output logic [9:0] mapa_x_read,
    output logic [9:0] mapa_y_read,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_clk,
    output logic       vblank,
    output logic       vblank_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_MID  = PW'(CLK_DIV / 2);

    localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE - 1);
    localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    logic [PW-1:0] ph, ph_next;
    logic [9:0]    h_cnt, v_cnt, h_next, v_next;
    logic          ph_last, active, hs_n, vs_n;

    always_comb begin
        ph_last = (ph == PH_LAST);
        ph_next = ph_last ? '0 : ph + PW'(1);
        h_next  = h_cnt;
        v_next  = v_cnt;
        if (ph_last) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
        active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_n   = !((h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI));
        vs_n   = !((v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI));
    end

    // Addresses are zeroed outside the visible area so the map never sees an out-of-range cell.
    assign vga_read    = active && (ph == '0);
    assign mapa_x_read = active ? {4'd0, h_cnt[9:4]} : '0;
    assign mapa_y_read = active ? {4'd0, v_cnt[9:4]} : '0;
    assign vblank      = (v_cnt >= V_VIS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph    <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            ph    <= ph_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Colour and syncs for pixel P are loaded together at the end of its period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r        <= '0;
            vga_g        <= '0;
            vga_b        <= '0;
            vga_hs       <= 1'b1;
            vga_vs       <= 1'b1;
            vga_blank_n  <= 1'b0;
            vga_clk      <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            if (ph_last) begin
                vga_r       <= active ? {4{mapa_R}} : '0;
                vga_g       <= active ? {4{mapa_G}} : '0;
                vga_b       <= active ? {4{mapa_B}} : '0;
                vga_hs      <= hs_n;
                vga_vs      <= vs_n;
                vga_blank_n <= active;
            end
            if (ph_next == '0)
                vga_clk <= 1'b0;
            else if (ph_next == PH_MID)
                vga_clk <= 1'b1;
            vblank_start <= ph_last && (h_cnt == H_LAST) && (v_cnt == V_VIS_END);
        end
    end

endmodule

// File: tb/tb_varredura_vga.sv
// Scoreboard bench for varredura_vga on a scaled raster; expectations come from
// a time-to-pixel arithmetic model and a behavioural one-clk-latency map.
module tb_varredura_vga;

    localparam int CD = 2;
    localparam int HV = 48, HF = 4, HS = 6, HB = 6;
    localparam int VV = 40, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = HT * VT * CD;

    typedef struct {
        int rd; int mx; int my; int vb; int vbs; int vclk;
    } cyc_t;
    typedef struct {
        int x; int y; int r; int g; int b; int hs; int vs; int bl;
    } pix_t;

    logic       clk, rst_n;
    logic [1:0] mapa_R, mapa_G, mapa_B;
    logic       vga_read, vga_hs, vga_vs, vga_blank_n, vga_clk, vblank, vblank_start;
    logic [9:0] mapa_x_read, mapa_y_read;
    logic [7:0] vga_r, vga_g, vga_b;

    varredura_vga #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mapa_R(mapa_R), .mapa_G(mapa_G), .mapa_B(mapa_B),
        .vga_read(vga_read), .mapa_x_read(mapa_x_read), .mapa_y_read(mapa_y_read),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_clk(vga_clk), .vblank(vblank), .vblank_start(vblank_start)
    );

    int   checks = 0;
    int   errors = 0;
    cyc_t cq[$];
    pix_t pq[$];
    logic [1:0] t_r[4][4], t_g[4][4], t_b[4][4];
    bit   const_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural map: registered read, data valid the clk after the strobe.
    always @(posedge clk) begin
        if (vga_read === 1'b1) begin
            if (const_mode) begin
                mapa_R <= 2'b11; mapa_G <= 2'b11; mapa_B <= 2'b11;
            end else if (mapa_x_read < 4 && mapa_y_read < 4) begin
                mapa_R <= t_r[mapa_x_read[1:0]][mapa_y_read[1:0]];
                mapa_G <= t_g[mapa_x_read[1:0]][mapa_y_read[1:0]];
                mapa_B <= t_b[mapa_x_read[1:0]][mapa_y_read[1:0]];
            end else begin
                mapa_R <= 2'b00; mapa_G <= 2'b00; mapa_B <= 2'b00;
            end
        end
    end

    function automatic int rep4(input int c);
        return c * 8'h55;
    endfunction

    function automatic int colour(input bit cst, input int c);
        return cst ? 3 : c;
    endfunction

    // Reference: clocks since reset release -> pixel coordinates and expected outputs.
    function automatic void push(input int t);
        int n, ph, f, x, y;
        bit act;
        cyc_t c;
        pix_t p;
        n   = t / CD;
        ph  = t % CD;
        f   = n % (HT * VT);
        x   = f % HT;
        y   = f / HT;
        act = (x < HV) && (y < VV);
        c.rd   = (act && ph == 0) ? 1 : 0;
        c.mx   = act ? x / 16 : 0;
        c.my   = act ? y / 16 : 0;
        c.vb   = (y >= VV) ? 1 : 0;
        c.vbs  = (x == 0 && y == VV && ph == 0) ? 1 : 0;
        c.vclk = (ph >= CD / 2) ? 1 : 0;
        cq.push_back(c);
        if (ph == 0) begin
            p.x  = x;
            p.y  = y;
            p.r  = act ? rep4(colour(const_mode, int'(t_r[x/16][y/16]))) : 0;
            p.g  = act ? rep4(colour(const_mode, int'(t_g[x/16][y/16]))) : 0;
            p.b  = act ? rep4(colour(const_mode, int'(t_b[x/16][y/16]))) : 0;
            p.hs = (x >= HV + HF && x < HV + HF + HS) ? 0 : 1;
            p.vs = (y >= VV + VF && y < VV + VF + VS) ? 0 : 1;
            p.bl = act ? 1 : 0;
            pq.push_back(p);
        end
    endfunction

    initial begin
        int t;
        forever begin
            wait (rst_n === 1'b1);
            t = 0;
            push(t);
            while (rst_n === 1'b1) begin
                @(posedge clk or negedge rst_n);
                if (rst_n !== 1'b1) break;
                #1;
                if (rst_n !== 1'b1) break;
                t++;
                push(t);
            end
        end
    end

    // Monitor: per-cycle combinational outputs, per-pixel registered outputs on vga_clk fall.
    bit prev_vclk = 0;
    bit seen_vbs  = 0;
    int rd_cnt    = 0;
    int clk_cnt   = 0;
    always @(negedge clk) begin
        cyc_t c;
        pix_t p;
        if (rst_n !== 1'b1) begin
            prev_vclk = 0;
            seen_vbs  = 0;
            rd_cnt    = 0;
            clk_cnt   = 0;
        end else begin
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL cycle_expectation: queue empty, expected an entry (t=%0t)", $time);
            end else begin
                c = cq.pop_front();
                chk("vga_read", vga_read, c.rd);
                chk("mapa_x_read", mapa_x_read, c.mx);
                chk("mapa_y_read", mapa_y_read, c.my);
                chk("vblank", vblank, c.vb);
                chk("vblank_start", vblank_start, c.vbs);
                chk("vga_clk", vga_clk, c.vclk);
            end
            if (prev_vclk && vga_clk === 1'b0) begin
                if (pq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pixel_expectation: vga_clk fell with no pixel pending (t=%0t)", $time);
                end else begin
                    p = pq.pop_front();
                    chk($sformatf("vga_r(%0d,%0d)", p.x, p.y), vga_r, p.r);
                    chk($sformatf("vga_g(%0d,%0d)", p.x, p.y), vga_g, p.g);
                    chk($sformatf("vga_b(%0d,%0d)", p.x, p.y), vga_b, p.b);
                    chk($sformatf("vga_hs(%0d,%0d)", p.x, p.y), vga_hs, p.hs);
                    chk($sformatf("vga_vs(%0d,%0d)", p.x, p.y), vga_vs, p.vs);
                    chk($sformatf("vga_blank_n(%0d,%0d)", p.x, p.y), vga_blank_n, p.bl);
                end
            end
            prev_vclk = (vga_clk === 1'b1);
            clk_cnt++;
            if (vga_read === 1'b1) rd_cnt++;
            if (vblank_start === 1'b1) begin
                if (seen_vbs) begin
                    chk("reads_per_frame", rd_cnt, HV * VV);
                    chk("frame_period_clk", clk_cnt, FRAME_CLK);
                end
                seen_vbs = 1;
                rd_cnt   = 0;
                clk_cnt  = 0;
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_vga_hs", vga_hs, 1);
        chk("rst_vga_vs", vga_vs, 1);
        chk("rst_vga_blank_n", vga_blank_n, 0);
        chk("rst_vga_r", vga_r, 0);
        chk("rst_vga_g", vga_g, 0);
        chk("rst_vga_b", vga_b, 0);
        chk("rst_vga_clk", vga_clk, 0);
        chk("rst_vblank_start", vblank_start, 0);
        chk("rst_vblank", vblank, 0);
        chk("rst_vga_read", vga_read, 1);
        chk("rst_mapa_x_read", mapa_x_read, 0);
        chk("rst_mapa_y_read", mapa_y_read, 0);
    endtask

    // Reset is asserted mid-cycle so the check shows it acts without a clk edge.
    task automatic apply_reset(input bit cst);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        cq.delete();
        pq.delete();
        #1;
        check_reset_values();
        const_mode = cst;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                t_r[i][j] = 2'($urandom_range(0, 3));
                t_g[i][j] = 2'($urandom_range(0, 3));
                t_b[i][j] = 2'($urandom_range(0, 3));
            end
        t_r[0][0] = 2'b11;
        t_g[2][2] = 2'b01;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        mapa_R = 2'b00;
        mapa_G = 2'b00;
        mapa_B = 2'b00;
        apply_reset(1'b0);
        repeat (FRAME_CLK + FRAME_CLK / 2 + 37) @(posedge clk);
        apply_reset(1'b0);
        repeat (2 * FRAME_CLK + 500) @(posedge clk);
        apply_reset(1'b1);
        repeat (FRAME_CLK + 300) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pixel_queue_drained", (pq.size() <= 1) ? 1 : 0, 1);
        chk("cycle_queue_drained", (cq.size() <= 1) ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/varredura_vga.md
# varredura_vga

Raster scan generator and VGA output stage for the snake game display. Walks a 640x480@60 Hz raster, drives the game map's read port (`vga_read`, `mapa_x_read`, `mapa_y_read`) with 16x16-pixel cell addresses covering the 40x30 grid, and captures the returned 2-bit map colour one cycle later. It then expands that colour to 8 bits per channel and drives the registered DAC/sync signals (`vga_*`). It also exposes vertical-blank timing so game logic can update the map outside the visible area.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; even, >= 2 (map read latency is 1 clk).
- `H_VISIBLE`, 640 / `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal timing in pixels (`H_TOTAL` = 800).
- `V_VISIBLE`, 480 / `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical timing in lines (`V_TOTAL` = 525).
- `clk`  in  1  system clock (50 MHz nominal).
- `rst_n`  in  1  asynchronous, active-low reset.
- `mapa_R`, `mapa_G`, `mapa_B`  in  2 each  map colour for the cell addressed in the previous clk.
- `vga_read`  out  1  map read strobe.
- `mapa_x_read`  out  10  cell column (0..39).
- `mapa_y_read`  out  10  cell row (0..29).
- `vga_r`, `vga_g`, `vga_b`  out  8 each  DAC colour.
- `vga_hs`, `vga_vs`  out  1  syncs, active low.
- `vga_blank_n`  out  1  high on visible pixels.
- `vga_clk`  out  1  DAC pixel clock.
- `vblank`  out  1  level, high while `v_cnt` >= `V_VISIBLE`.
- `vblank_start`  out  1  one-clk pulse at entry to vertical blank.

## Operation
- Phase counter `ph` runs 0..CLK_DIV-1 and wraps. Pixel counters are `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1).
- On the clk edge where `ph == CLK_DIV-1`, `h_cnt` increments. At `H_TOTAL-1` it wraps to 0 and `v_cnt` increments. At `V_TOTAL-1` `v_cnt` wraps to 0.
- Pixel P is "active" when `h_cnt < H_VISIBLE` and `v_cnt < V_VISIBLE`.
- `vga_read` is high when P is active and `ph == 0`, and low otherwise. It never asserts during blanking.
- Addresses are combinational from the counters:
  - When active: `mapa_x_read = h_cnt >> 4` and `mapa_y_read = v_cnt >> 4`.
  - When not active: both are 0, so no out-of-range index reaches the map.
- Output register, loaded on the edge where `ph == CLK_DIV-1`, with the values for pixel P:
  - `vga_r/g/b` = the 2-bit colour replicated four times ({c,c,c,c}: 00→00, 01→55, 10→AA, 11→FF). Forced to 0 when P is not active.
  - `vga_hs` = 0 iff `H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC`.
  - `vga_vs` = 0 iff `V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC`.
  - `vga_blank_n` = active(P).
- `vga_clk` is registered: driven 0 on the edge entering `ph == 0`, and 1 on the edge entering `ph == CLK_DIV/2`.
- `vblank_start` is registered. It is high for exactly one clk, following the edge where the counters move from (`H_TOTAL-1`, `V_VISIBLE-1`) to (0, `V_VISIBLE`).
- Counter arithmetic is 10-bit unsigned with explicit wrap compares; there is no reliance on overflow.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - `ph`, `h_cnt`, `v_cnt` = 0.
  - `vga_hs` = `vga_vs` = 1; `vga_blank_n` = 0; `vga_r/g/b` = 0; `vga_clk` = 0; `vblank_start` = 0.
  - `vga_read` = 1 and addresses = 0 while in reset, since (0,0) is active and `ph` = 0. The map tolerates this.
- After `rst_n` rises, scanning restarts at pixel (0,0); the first `vga_read` occurs in the first clk.
- Map latency is 1 clk:
  - Address and strobe are presented in the `ph == 0` cycle.
  - `mapa_R/G/B` are valid from the next cycle through the end of the pixel period.
  - The output register samples them at the end of the period.
- All `vga_*` colour and sync outputs change only on the edge entering `ph == 0`. They lag the counters by exactly one pixel period and stay stable for CLK_DIV clocks.
- Sync and colour are always aligned to the same pixel; there are no mixed-pixel outputs.
- `vga_clk` rises CLK_DIV/2 clocks after the outputs change, i.e. mid-pixel.
- At CLK_DIV = 2:
  - Line = 1600 clk; frame = 840000 clk.
  - `vga_hs` low 192 clk per line.
  - `vga_vs` low 3200 clk per frame.

## Test plan
- Reset: assert `rst_n` = 0 mid-frame → all outputs at their reset values immediately, without waiting for a clk edge. After release, `vga_read` is high at x=0,y=0 in clk 0, and the first `vga_blank_n` = 1 appears 2 clk later.
- Line timing (CLK_DIV = 2) → `vga_hs` falls 1312 clk after line start (+2 clk output lag) and stays low for 192 clk; line period is 1600 clk; `vga_blank_n` is high for 1280 clk per line.
- Frame timing → `vga_vs` low for 2 lines; frame period 840000 clk; exactly one `vblank_start` per frame; `vblank` high for 45 lines; exactly 307200 `vga_read` pulses per frame.
- Addressing → at pixel (37,21), `mapa_x_read` = 2 and `mapa_y_read` = 1; at (639,479), 39 and 29; during blanking, addresses = 0 and `vga_read` = 0.
- Colour path: behavioural map returns R=11 at cell (0,0) and G=01 at (10,10) → `vga_r` = FF on pixels 0..15 of lines 0..15; `vga_g` = 55 on pixels 160..175 of lines 160..175, each one pixel period after its read.
- Blanking override: drive `mapa_R/G/B` = 11 constantly → `vga_r/g/b` = 0 whenever `vga_blank_n` = 0.
